// File: rtl/uart_par_pkg.sv
// Shared parity mode encodings and TX FSM state type for the UART parity engine.
package uart_par_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_parity_reduce.sv
// Combinational parity over the low active data bits, followed by the parity-mode select.
module uart_parity_reduce
  import uart_par_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int DLEN_W    = $clog2(DATA_SIZE) + 1
) (
  input  logic [DATA_SIZE-1:0] data,
  input  logic [DLEN_W-1:0]    dlen,
  input  logic                 par_en,
  input  logic [1:0]           par_typ,
  output logic                 par_bit
);

  logic [DLEN_W-1:0] eff_len;
  logic              xor_acc;

  // Out-of-range lengths fall back to the full word width.
  always_comb begin
    eff_len = dlen;
    if (dlen == '0 || dlen > DLEN_W'(DATA_SIZE)) begin
      eff_len = DLEN_W'(DATA_SIZE);
    end
    xor_acc = 1'b0;
    for (int i = 0; i < DATA_SIZE; i++) begin
      if (DLEN_W'(i) < eff_len) begin
        xor_acc = xor_acc ^ data[i];
      end
    end
  end

  always_comb begin
    par_bit = 1'b0;
    if (par_en) begin
      case (par_typ)
        PAR_EVEN:  par_bit = xor_acc;
        PAR_ODD:   par_bit = ~xor_acc;
        PAR_MARK:  par_bit = 1'b1;
        PAR_SPACE: par_bit = 1'b0;
        default:   par_bit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/uart_parity_engine.sv
// UART parity engine: TX parity capture with valid/ack hold, RX parity check with sticky flag
// and saturating error counter.
module uart_parity_engine
  import uart_par_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int DLEN_W    = $clog2(DATA_SIZE) + 1,
  parameter int CNT_W     = 8
) (
  input  logic                 CLK_PE,
  input  logic                 RST_PE,
  input  logic                 CFG_PAR_EN,
  input  logic [1:0]           CFG_PAR_TYP,
  input  logic [DLEN_W-1:0]    CFG_DLEN,
  input  logic [DATA_SIZE-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  output logic                 TX_PAR_BIT,
  output logic                 TX_PAR_VALID,
  input  logic                 TX_PAR_ACK,
  input  logic [DATA_SIZE-1:0] RX_DATA,
  input  logic                 RX_PAR_IN,
  input  logic                 RX_VALID,
  output logic                 RX_PAR_ERR,
  output logic                 RX_ERR_STICKY,
  output logic [CNT_W-1:0]     RX_ERR_CNT,
  input  logic                 ERR_CLR
);

  tx_state_e        tx_state_q, tx_state_d;
  logic             tx_par_bit_q, tx_par_bit_d;
  logic             rx_err_q, rx_err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_par_calc;
  logic             rx_par_calc;

  uart_parity_reduce #(.DATA_SIZE(DATA_SIZE), .DLEN_W(DLEN_W)) u_tx_reduce (
    .data    (TX_DATA),
    .dlen    (CFG_DLEN),
    .par_en  (CFG_PAR_EN),
    .par_typ (CFG_PAR_TYP),
    .par_bit (tx_par_calc)
  );

  uart_parity_reduce #(.DATA_SIZE(DATA_SIZE), .DLEN_W(DLEN_W)) u_rx_reduce (
    .data    (RX_DATA),
    .dlen    (CFG_DLEN),
    .par_en  (CFG_PAR_EN),
    .par_typ (CFG_PAR_TYP),
    .par_bit (rx_par_calc)
  );

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_par_bit_d = tx_par_bit_q;
    case (tx_state_q)
      ST_IDLE: begin
        if (TX_VALID) begin
          tx_par_bit_d = tx_par_calc;
          tx_state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (TX_PAR_ACK) begin
          tx_state_d = ST_IDLE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // A clear lands before a same-cycle error, so that error still counts as the first.
  always_comb begin
    rx_err_d = RX_VALID && CFG_PAR_EN && (rx_par_calc != RX_PAR_IN);
    sticky_d = ERR_CLR ? 1'b0 : sticky_q;
    cnt_d    = ERR_CLR ? '0 : cnt_q;
    if (rx_err_d) begin
      sticky_d = 1'b1;
      if (cnt_d != '1) begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_PE) begin
    if (RST_PE) begin
      tx_state_q   <= ST_IDLE;
      tx_par_bit_q <= 1'b0;
      rx_err_q     <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_par_bit_q <= tx_par_bit_d;
      rx_err_q     <= rx_err_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign TX_READY      = (tx_state_q == ST_IDLE);
  assign TX_PAR_VALID  = (tx_state_q == ST_HOLD);
  assign TX_PAR_BIT    = tx_par_bit_q;
  assign RX_PAR_ERR    = rx_err_q;
  assign RX_ERR_STICKY = sticky_q;
  assign RX_ERR_CNT    = cnt_q;

endmodule
